// File: rtl/normal_pipe_arbiter.sv
// Round-robin arbiter sharing one ray_sphere_normal_pipeline among NREQ requesters.
// Optional perf counters are enabled with `define NORMAL_ARB_PERF_EN.
module normal_pipe_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*96-1:0] req_sphere_center,
  input  logic [NREQ*96-1:0] req_hit_pos,
  output logic [NREQ-1:0]   req_ready,
  output logic [95:0]       pipe_sphere_center,
  output logic [95:0]       pipe_hit_pos,
  output logic              pipe_new_data,
  input  logic [95:0]       pipe_normal,
  input  logic              pipe_output_valid,
  output logic [NREQ-1:0]   resp_valid,
  output logic [95:0]       resp_normal,
  output logic              err_orphan
`ifdef NORMAL_ARB_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      rst_sync;
  logic            arb_en;
  logic [NREQ-1:0] busy;
  logic [IW-1:0]   ptr;
  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cidx;

  logic [95:0]     ctr_arr [NREQ];
  logic [95:0]     hit_arr [NREQ];

  // Tag pipeline: stage 0 lines up with pipe_new_data, stage LATENCY with pipe_output_valid.
  // tag_k marks entries killed by flush so their results drop silently.
  logic [LATENCY:0] tag_v;
  logic [LATENCY:0] tag_k;
  logic [IW-1:0]    tag_idx [LATENCY+1];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign ctr_arr[g] = req_sphere_center[96*g +: 96];
    assign hit_arr[g] = req_hit_pos[96*g +: 96];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign arb_en = rst_sync[1];

  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cidx      = '0;
    if (arb_en && !flush) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cidx = IW'((32'(ptr) + i) % NREQ);
        if (!gnt_any && req_valid[cidx] && !busy[cidx]) begin
          gnt_any = 1'b1;
          gnt_idx = cidx;
        end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr  <= '0;
      busy <= '0;
    end else begin
      if (gnt_any)
        ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      if (flush) busy <= '0;
      else       busy <= (busy & ~resp_valid) | req_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_new_data      <= 1'b0;
      pipe_sphere_center <= '0;
      pipe_hit_pos       <= '0;
    end else begin
      pipe_new_data <= gnt_any;
      if (gnt_any) begin
        pipe_sphere_center <= ctr_arr[gnt_idx];
        pipe_hit_pos       <= hit_arr[gnt_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      tag_k <= '0;
      for (int unsigned k = 0; k <= LATENCY; k++) tag_idx[k] <= '0;
    end else begin
      tag_v[0]   <= gnt_any;
      tag_k[0]   <= 1'b0;
      tag_idx[0] <= gnt_idx;
      for (int unsigned k = 1; k <= LATENCY; k++) begin
        tag_v[k]   <= tag_v[k-1] & ~flush;
        tag_k[k]   <= tag_k[k-1] | (tag_v[k-1] & flush);
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid  <= '0;
      resp_normal <= '0;
      err_orphan  <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (pipe_output_valid && !flush) begin
        if (tag_v[LATENCY]) begin
          resp_valid[tag_idx[LATENCY]] <= 1'b1;
          resp_normal                  <= pipe_normal;
        end else if (!tag_k[LATENCY]) begin
          err_orphan <= 1'b1;
        end
      end
    end
  end

`ifdef NORMAL_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pipe_new_data && perf_issue_cnt != '1)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((|req_valid) && !gnt_any && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_normal_pipe_arbiter.sv
// Directed self-checking bench for normal_pipe_arbiter (default build, NREQ=4, LATENCY=2).
// Includes a behavioural stand-in for the normal pipeline: normal = hit - center, 2-cycle latency.
module tb_normal_pipe_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*96-1:0] req_sphere_center = '0;
  logic [NREQ*96-1:0] req_hit_pos = '0;
  logic [NREQ-1:0]   req_ready;
  logic [95:0]       pipe_sphere_center;
  logic [95:0]       pipe_hit_pos;
  logic              pipe_new_data;
  logic [95:0]       pipe_normal;
  logic              pipe_output_valid;
  logic [NREQ-1:0]   resp_valid;
  logic [95:0]       resp_normal;
  logic              err_orphan;
  logic              inject = 1'b0;

  logic        m1_v, m2_v;
  logic [95:0] m1_d, m2_d;

  int n_chk = 0;
  int n_err = 0;

  normal_pipe_arbiter #(.NREQ(NREQ), .LATENCY(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .req_valid         (req_valid),
    .req_sphere_center (req_sphere_center),
    .req_hit_pos       (req_hit_pos),
    .req_ready         (req_ready),
    .pipe_sphere_center(pipe_sphere_center),
    .pipe_hit_pos      (pipe_hit_pos),
    .pipe_new_data     (pipe_new_data),
    .pipe_normal       (pipe_normal),
    .pipe_output_valid (pipe_output_valid),
    .resp_valid        (resp_valid),
    .resp_normal       (resp_normal),
    .err_orphan        (err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] vec3(input int x, input int y, input int z);
    return {32'(x), 32'(y), 32'(z)};
  endfunction

  function automatic logic [95:0] vsub(input logic [95:0] a, input logic [95:0] b);
    return {a[95:64] - b[95:64], a[63:32] - b[63:32], a[31:0] - b[31:0]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_v <= 1'b0; m2_v <= 1'b0; m1_d <= '0; m2_d <= '0;
    end else begin
      m1_v <= pipe_new_data;
      m1_d <= vsub(pipe_hit_pos, pipe_sphere_center);
      m2_v <= m1_v;
      m2_d <= m1_d;
    end
  end

  assign pipe_output_valid = m2_v | inject;
  assign pipe_normal       = m2_d;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [95:0] c, input logic [95:0] h);
    req_sphere_center[96*i +: 96] = c;
    req_hit_pos[96*i +: 96]       = h;
  endtask

  // Ends in the cycle where rst has just risen.
  task automatic do_reset;
    rst = 1'b0; flush = 1'b0; inject = 1'b0; req_valid = '1;
    tick;
    tick;
    chk("rst_ready", req_ready, 0);
    chk("rst_issue", pipe_new_data, 0);
    chk("rst_center", pipe_sphere_center, 0);
    chk("rst_hit", pipe_hit_pos, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_normal", resp_normal, 0);
    chk("rst_orphan", err_orphan, 0);
    req_valid = '0;
    rst = 1'b1;
  endtask

  initial begin
    // Single op through the pipe, including the reset-release synchroniser.
    do_reset;
    set_op(0, vec3(1, 2, 3), vec3(4, 6, 8));
    req_valid = 4'b0001;
    #1 chk("sync0_ready", req_ready, 0);
    tick; chk("sync1_ready", req_ready, 0);
    tick; chk("t1_ready", req_ready, 4'b0001);
    tick; req_valid = '0; #1;
    chk("t1_issue", pipe_new_data, 1);
    chk("t1_center", pipe_sphere_center, vec3(1, 2, 3));
    chk("t1_hit", pipe_hit_pos, vec3(4, 6, 8));
    tick; chk("t1_issue_end", pipe_new_data, 0); chk("t1_resp2", resp_valid, 0);
    tick; chk("t1_resp3", resp_valid, 0);
    tick; chk("t1_resp4", resp_valid, 4'b0001); chk("t1_normal", resp_normal, vec3(3, 4, 5));
    chk("t1_orphan", err_orphan, 0);
    tick; chk("t1_resp5", resp_valid, 0);

    // Full-throughput round robin over all requesters.
    do_reset; tick; tick;
    for (int i = 0; i < NREQ; i++) set_op(i, vec3(i, 1, 0), vec3(i + 5, 2*i + 1, 3*i + 1));
    for (int t = 0; t < 9; t++) begin
      req_valid = (t < 4) ? 4'(4'b1111 << t) : 4'b0000;
      #1;
      chk("rr_ready", req_ready, (t < 4) ? (1 << t) : 0);
      chk("rr_issue", pipe_new_data, (t >= 1 && t <= 4) ? 1 : 0);
      chk("rr_resp", resp_valid, (t >= 4 && t < 8) ? (1 << (t - 4)) : 0);
      if (t >= 4 && t < 8) chk("rr_normal", resp_normal, vec3(5, 2*(t - 4), 3*(t - 4) + 1));
      tick;
    end

    // Held request waits for its own response; then pointer rotation.
    do_reset; tick; tick;
    set_op(2, vec3(0, 0, 0), vec3(7, 8, 9));
    req_valid = 4'b0100;
    for (int t = 0; t < 6; t++) begin
      #1;
      chk("hold_ready", req_ready, (t == 0 || t == 5) ? 4'b0100 : 4'b0000);
      chk("hold_resp", resp_valid, (t == 4) ? 4'b0100 : 4'b0000);
      if (t == 4) chk("hold_normal", resp_normal, vec3(7, 8, 9));
      tick;
    end
    req_valid = 4'b1011; #1 chk("rot_ready3", req_ready, 4'b1000);
    tick; req_valid = 4'b0011; #1 chk("rot_ready0", req_ready, 4'b0001);
    tick; req_valid = '0;

    // Flush one cycle after the last of three grants.
    do_reset; tick; tick;
    for (int i = 0; i < 3; i++) set_op(i, vec3(0, 0, 0), vec3(10 + i, 11 + i, 12 + i));
    req_valid = 4'b0111; #1 chk("fl_ready0", req_ready, 4'b0001);
    tick; req_valid = 4'b0110; #1 chk("fl_ready1", req_ready, 4'b0010);
    tick; req_valid = 4'b0100; #1 chk("fl_ready2", req_ready, 4'b0100);
    tick; flush = 1'b1; req_valid = 4'b1000; #1 chk("fl_ready_flush", req_ready, 0);
    tick; flush = 1'b0;
    set_op(0, vec3(0, 0, 0), vec3(20, 21, 22));
    req_valid = 4'b0111; #1;
    chk("fl_regrant", req_ready, 4'b0001);
    chk("fl_resp4", resp_valid, 0);
    chk("fl_orphan4", err_orphan, 0);
    tick; req_valid = '0;
    for (int t = 5; t <= 8; t++) begin
      #1;
      chk("fl_resp", resp_valid, (t == 8) ? 4'b0001 : 4'b0000);
      chk("fl_orphan", err_orphan, 0);
      if (t == 8) chk("fl_normal", resp_normal, vec3(20, 21, 22));
      tick;
    end

    // Orphan result: sticky until reset.
    do_reset; tick; tick;
    inject = 1'b1;
    tick; inject = 1'b0; #1;
    chk("orph_set", err_orphan, 1);
    chk("orph_resp", resp_valid, 0);
    tick; chk("orph_hold1", err_orphan, 1);
    tick; chk("orph_hold2", err_orphan, 1);
    rst = 1'b0; #1 chk("orph_clear", err_orphan, 0);
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
